// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-slave / RAM subsystem.
package spi_pkg;

    localparam int unsigned FRAME_W_DEF = 10;
    localparam int unsigned DATA_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // Opcodes carried in rx_data[9:8]; decoded by the RAM, not by the serial front end.
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises MOSI frames into words for the RAM and
// serialises RAM read data back on MISO, MSB first.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int unsigned CNT_W = $clog2(FRAME_W);
    localparam int unsigned TXC_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 2);
    localparam logic [CNT_W-1:0] RX_DONE = CNT_W'(FRAME_W - 1);
    localparam logic [TXC_W-1:0] TX_LOAD = TXC_W'(DATA_W - 1);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-2:0] r_rx_shift;
    logic [DATA_W-1:0]  r_tx_shift;
    logic [TXC_W-1:0]   r_tx_cnt;
    logic               r_tx_busy;
    logic               r_tx_done;
    logic               r_rd_addr_seen;
    logic               w_rx_sample;
    logic               w_rx_last;
    logic               w_tx_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the per-cycle receive/transmit strobes; SS_n high always wins.
    always_comb begin
        w_next      = r_state;
        w_rx_sample = 1'b0;
        w_rx_last   = 1'b0;
        w_tx_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!SS_n) begin
                    w_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    w_next = IDLE;
                end else begin
                    w_rx_sample = 1'b1;
                    if (!MOSI) begin
                        w_next = WRITE;
                    end else if (r_rd_addr_seen) begin
                        w_next = READ_DATA;
                    end else begin
                        w_next = READ_ADD;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    w_next = IDLE;
                end else if (r_cnt != RX_DONE) begin
                    w_rx_sample = 1'b1;
                    w_rx_last   = (r_cnt == RX_LAST);
                end else if ((r_state == READ_DATA) && tx_valid && !r_tx_busy && !r_tx_done) begin
                    w_tx_start = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Receive bit counter: counts payload bits after the command bit, parks at RX_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (SS_n || (r_state == IDLE) || (r_state == CHK_CMD)) begin
            r_cnt <= '0;
        end else if (w_rx_sample) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift     <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            r_rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= w_rx_last;
            if (w_rx_sample) begin
                r_rx_shift <= {r_rx_shift[FRAME_W-3:0], MOSI};
            end
            if (w_rx_last) begin
                rx_data <= {r_rx_shift, MOSI};
                if (r_state == READ_ADD) begin
                    r_rd_addr_seen <= 1'b1;
                end else if (r_state == READ_DATA) begin
                    r_rd_addr_seen <= 1'b0;
                end
            end
        end
    end

    // One transmission per READ_DATA frame; r_tx_done blocks re-triggering until SS_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MISO       <= 1'b0;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else if (SS_n || (r_state != READ_DATA)) begin
            MISO       <= 1'b0;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else if (w_tx_start) begin
            MISO       <= tx_data[DATA_W-1];
            r_tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
            r_tx_cnt   <= TX_LOAD;
            r_tx_busy  <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_cnt != '0) begin
                MISO       <= r_tx_shift[DATA_W-1];
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                r_tx_cnt   <= r_tx_cnt - 1'b1;
            end else begin
                MISO      <= 1'b0;
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: inputs driven and outputs sampled on the falling clock edge.
module tb_spi_slave;
    import spi_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   SS_n;
    logic                   MOSI;
    logic                   MISO;
    logic [FRAME_W_DEF-1:0] rx_data;
    logic                   rx_valid;
    logic [DATA_W_DEF-1:0]  tx_data;
    logic                   tx_valid;

    int n_err = 0;
    int n_chk = 0;

    spi_slave #(
        .FRAME_W (FRAME_W_DEF),
        .DATA_W  (DATA_W_DEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a frame from IDLE; nbits < 10 raises SS_n on the edge that samples bit nbits.
    task automatic frame(input logic [9:0] w, input int nbits);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            chk("rx_valid_low", 16'(rx_valid), 16'h0);
            chk("miso_rx", 16'(MISO), 16'h0);
            MOSI = w[9-i];
        end
        if (nbits < 10) begin
            @(negedge clk);
            SS_n = 1'b1;
            MOSI = w[9-nbits];
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("abort_no_valid", 16'(rx_valid), 16'h0);
                chk("abort_miso", 16'(MISO), 16'h0);
            end
        end else begin
            @(negedge clk);
            chk("rx_valid_pulse", 16'(rx_valid), 16'h1);
            chk("rx_data", 16'(rx_data), 16'(w));
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        chk("rx_valid_single", 16'(rx_valid), 16'h0);
        chk("miso_pre_end", 16'(MISO), 16'h0);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        chk("miso_idle", 16'(MISO), 16'h0);
    endtask

    // Called in the rx_valid cycle; drives tx_valid, a second pulse mid-shift and a late pulse.
    task automatic tx_phase(input logic [7:0] d, input logic active);
        tx_valid = 1'b1;
        tx_data  = d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk("rx_valid_drop", 16'(rx_valid), 16'h0);
            chk(active ? "miso_bit" : "miso_quiet", 16'(MISO), 16'(active ? d[7-k] : 1'b0));
            tx_valid = (k == 3);
            tx_data  = ~d;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("miso_after_tx", 16'(MISO), 16'h0);
            tx_valid = (k == 0);
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_miso", 16'(MISO), 16'h0);
        chk("reset_rx_valid", 16'(rx_valid), 16'h0);
        chk("reset_rx_data", 16'(rx_data), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        frame(10'h0A5, 10);
        end_frame();
        frame(10'h13C, 10);
        end_frame();

        // Read address first: no read data may be returned.
        frame(10'h2A5, 10);
        tx_phase(8'h5A, 1'b0);
        end_frame();
        frame(10'h300, 10);
        tx_phase(8'h3C, 1'b1);
        end_frame();

        // Read-address flag was cleared by the READ_DATA frame.
        frame(10'h3C3, 10);
        tx_phase(8'hFF, 1'b0);
        end_frame();

        // Aborts must not disturb the read-address flag set above.
        frame(10'h3F0, 6);
        frame(10'h0FF, 10);
        end_frame();
        frame(10'h2AA, 9);
        frame(10'h355, 10);
        tx_phase(8'hA5, 1'b1);
        end_frame();

        // Asynchronous reset in the middle of a transmission.
        frame(10'h280, 10);
        end_frame();
        frame(10'h3FF, 10);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("miso_pre_reset0", 16'(MISO), 16'h1);
        @(negedge clk);
        chk("miso_pre_reset1", 16'(MISO), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_miso", 16'(MISO), 16'h0);
        chk("async_reset_rx_valid", 16'(rx_valid), 16'h0);
        chk("async_reset_rx_data", 16'(rx_data), 16'h0);
        @(negedge clk);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset cleared the read-address flag.
        frame(10'h311, 10);
        tx_phase(8'hFF, 1'b0);
        end_frame();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Serial front end of the SPI-slave/RAM subsystem, directly upstream of the single-port RAM.
- Deserialises MOSI frames into 10-bit words with a one-cycle rx_valid strobe for the RAM.
- Captures the RAM's 8-bit read data on tx_valid and serialises it back on MISO, MSB first.
- Sits between the chip pins (MOSI, MISO, SS_n) and the RAM; the top-level wrapper connects the two.

Parameters:
- FRAME_W, 10, bits per received word (2-bit opcode + 8-bit payload); RAM din width.
- DATA_W, 8, bits of read data returned on MISO; RAM dout width.

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst_n  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- SS_n  in  1  slave select, active-low; a frame lasts while low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  FRAME_W  assembled word to RAM din; [9:8] is the opcode.
- rx_valid  out  1  one-cycle strobe, rx_data complete.
- tx_data  in  DATA_W  RAM dout.
- tx_valid  in  1  RAM dout valid strobe.

Behaviour:
- Reset (async, any time): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx shift register cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 sampled -> CHK_CMD. No data is taken this cycle.
- CHK_CMD: SS_n=1 -> IDLE. Otherwise MOSI is shifted in as bit 9.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase: shift in 9 more bits (bits 8..0), one per cycle. The counter runs 1..9 after CHK_CMD.
- On the cycle the 10th bit is sampled:
  - rx_data updates to the full word in the following cycle.
  - rx_valid=1 for exactly that cycle, then 0.
  - Bit latency: SS_n fall to rx_valid = 11 clocks.
- Bits after the 10th are ignored. The FSM holds its state until SS_n=1.
- rd_addr_seen: set at rx_valid in READ_ADD; cleared at rx_valid in READ_DATA; unchanged otherwise, including on aborted frames.
- READ_DATA transmit phase:
  - After rx_valid, wait for tx_valid=1. On that edge, capture tx_data.
  - MISO drives tx_data[7] on the next cycle, then [6]..[0] over the following 7 cycles (8 cycles total).
  - MISO returns to 0 afterwards.
- MISO=0 in every state and cycle other than the 8 transmit cycles.
- tx_valid outside the READ_DATA wait window is ignored.
- A second tx_valid during transmission is ignored; the shift is not restarted.
- SS_n=1 at any point:
  - Next state is IDLE; the partial word is discarded; no rx_valid is issued.
  - Counter cleared; MISO=0 from the next cycle; any transmission in progress is aborted.
- SS_n=1 on the same cycle the 10th bit is sampled: SS_n wins; no rx_valid.
- The opcode bit 8 is not interpreted here. Opcode meaning is the RAM's job, and the word is forwarded unchanged.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - opcode constants WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11;
  - FRAME_W/DATA_W defaults.
- No sub-module: FSM, rx shift register, tx shift register and counter live in one module.
- The RAM is instantiated alongside it in the top-level wrapper, not inside it.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> MISO=0, rx_valid=0, rx_data=0 immediately; the next frame starts from IDLE.
- Write address: SS_n low, shift 10'b00_1010_0101 -> rx_valid single pulse 11 clocks after SS_n fall, rx_data=10'h0A5; MISO stays 0.
- Write data: shift 10'b01_0011_1100 -> rx_data=10'h13C, one rx_valid; rd_addr_seen unchanged (0).
- Read sequence:
  - Frame 10'h2A5 -> READ_ADD taken, rx_data=10'h2A5.
  - Next frame 10'h300 -> READ_DATA taken.
  - Bench drives tx_valid with tx_data=8'h3C one cycle after rx_valid -> MISO=0,0,1,1,1,1,0,0 over the next 8 cycles.
  - rd_addr_seen is cleared afterwards.
- Abort: raise SS_n after 6 bits -> no rx_valid; FSM back in IDLE next cycle; the following full frame 10'h0FF is received correctly.
- Read data without prior read address (rd_addr_seen=0, MSB=1) -> READ_ADD is taken, not READ_DATA; a tx_valid pulse is ignored and MISO stays 0.
